audio_level_meter: RTL

//  Parametrised stereo VU meter driving an LED bar. Accumulates L^2+R^2 over a window of
//  2^WIN_LOG2 valid samples, takes an iterative integer sqrt (RMS level), then drives
//  NUM_LEDS LEDs in bar or dot mode with a peak-hold/decay marker. Sits after the audio

---
 rtl/audio_level_meter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/audio_level_meter.sv
// audio_level_meter: stereo RMS VU meter with peak hold driving an LED bar/dot display
module audio_level_meter #(
  parameter int          SAMPLE_W = 16,
  parameter int          NUM_LEDS = 8,
  parameter int unsigned STEP     = 32'h0200,
  parameter int          WIN_LOG2 = 4,
  parameter int          HOLD_WIN = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       vld,
  input  logic signed [SAMPLE_W-1:0] lft_chnnl,
  input  logic signed [SAMPLE_W-1:0] rght_chnnl,
  input  logic                       mode,
  input  logic                       clr_ovr,
  output logic        [SAMPLE_W-1:0] level,
  output logic                       level_vld,
  output logic        [SAMPLE_W-1:0] peak,
  output logic                       overrun,
  output logic        [NUM_LEDS-1:0] LED
);
  localparam int MW = 2 * SAMPLE_W;
  localparam int AW = MW + WIN_LOG2;
  localparam int RQ = SAMPLE_W + 2;
  localparam int RW = SAMPLE_W + 4;
  localparam int CW = $clog2(SAMPLE_W + 1);
  localparam int TW = SAMPLE_W + $clog2(NUM_LEDS);
  localparam int HW = $clog2(HOLD_WIN + 1);
  localparam logic [SAMPLE_W-1:0] STEP_W = SAMPLE_W'(STEP);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state_q, state_d;
  logic [WIN_LOG2-1:0]  cnt_q;
  logic [AW-1:0]        acc_q, sum;
  logic signed [MW-1:0] l_sq, r_sq;
  logic [MW:0]          sq_sum;
  logic [MW-1:0]        ms, rad_q;
  logic [RQ-1:0]        rem_q;
  logic [RW-1:0]        rem_sh, trial;
  logic [SAMPLE_W-1:0]  root_q, root_nx, level_q, peak_q;
  logic [CW-1:0]        bit_q;
  logic [HW-1:0]        hold_q;
  logic [NUM_LEDS-1:0]  led_q, bar, pbar;
  logic                 win_end, start, last, ge, level_vld_q, overrun_q;

  assign l_sq    = MW'(lft_chnnl) * MW'(lft_chnnl);
  assign r_sq    = MW'(rght_chnnl) * MW'(rght_chnnl);
  assign sq_sum  = {1'b0, l_sq} + {1'b0, r_sq};
  assign sum     = acc_q + AW'(sq_sum >> 1);
  assign win_end = vld && &cnt_q;
  assign ms      = MW'(sum >> WIN_LOG2);
  assign start   = win_end && state_q == IDLE;
  assign last    = state_q == CALC && bit_q == CW'(SAMPLE_W - 1);
  assign rem_sh  = {rem_q, rad_q[MW-1 -: 2]};
  assign trial   = RW'({root_q, 2'b01});
  assign ge      = rem_sh >= trial;
  assign root_nx = {root_q[SAMPLE_W-2:0], ge};

  // Window accumulator; clears on the window's last sample so the next window starts clean
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (vld) begin
      acc_q <= win_end ? '0 : sum;
      cnt_q <= cnt_q + 1'b1;
    end

  // Sqrt FSM state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;

  // Sqrt FSM next state: one result bit per CALC cycle, then a single DONE cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = win_end ? CALC : IDLE;
      CALC:    state_d = last ? DONE : CALC;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Restoring square root: radicand consumed two bits per cycle from the top
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      bit_q  <= '0;
    end else if (start) begin
      rad_q  <= ms;
      rem_q  <= '0;
      root_q <= '0;
      bit_q  <= '0;
    end else if (state_q == CALC) begin
      rad_q  <= rad_q << 2;
      rem_q  <= RQ'(ge ? rem_sh - trial : rem_sh);
      root_q <= root_nx;
      bit_q  <= bit_q + 1'b1;
    end

  // Publish the result as the FSM enters DONE; a window ending while busy is dropped and flagged
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      level_q     <= '0;
      level_vld_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      level_vld_q <= last;
      if (last) level_q <= root_nx;
      overrun_q   <= (win_end && state_q != IDLE) || (overrun_q && !clr_ovr);
    end

  // Peak hold for HOLD_WIN results, then linear decay by STEP per result
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      peak_q <= '0;
      hold_q <= '0;
    end else if (level_vld_q) begin
      if (level_q >= peak_q) begin
        peak_q <= level_q;
        hold_q <= HW'(HOLD_WIN);
      end else if (hold_q != '0) hold_q <= hold_q - 1'b1;
      else peak_q <= peak_q > STEP_W ? peak_q - STEP_W : '0;
    end

  // Thermometer codes for level and peak against ascending thresholds i*STEP
  always_comb begin
    bar  = '0;
    pbar = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      bar[i]  = TW'(level_q) > TW'(i) * TW'(STEP_W);
      pbar[i] = TW'(peak_q) > TW'(i) * TW'(STEP_W);
    end
  end

  // LED drive: codes are thermometers, so x & ~(x >> 1) isolates the top lit LED
  always_ff @(posedge clk or posedge rst)
    if (rst) led_q <= '0;
    else     led_q <= (mode ? bar & ~(bar >> 1) : bar) | (pbar & ~(pbar >> 1));

  assign level     = level_q;
  assign level_vld = level_vld_q;
  assign peak      = peak_q;
  assign overrun   = overrun_q;
  assign LED       = led_q;
endmodule
